// File: rtl/dbus_pkg.sv
// Shared types and constants for the data-bus arbiter.
package dbus_pkg;

    localparam int DBUS_AW = 32;
    localparam int DBUS_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

endpackage

// File: rtl/dbus_arb_pick.sv
// Combinational winner select for the two data-bus masters.
// DBUS_ARB_RR_EN selects round-robin; otherwise fixed priority with a starvation override.
module dbus_arb_pick (
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    input  logic       i_bias,
    output logic       o_vld,
    output logic       o_m1
);

    logic [1:0] w_req;

    // i_mask removes the master being acked this cycle; i_bias is the RR pointer or force_m1
    assign w_req = i_req & ~i_mask;
    assign o_vld = |w_req;

`ifdef DBUS_ARB_RR_EN
    assign o_m1 = (&w_req) ? i_bias : w_req[1];
`else
    assign o_m1 = w_req[1] & (i_bias | ~w_req[0]);
`endif

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: IDLE -> ISSUE (s_en) -> RESP (ack), back-to-back capable.
// Define DBUS_ARB_RR_EN for round-robin; default is fixed priority with starvation override.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int AW           = DBUS_AW,
    parameter int DW           = DBUS_DW,
    parameter int STARVE_LIMIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          s_en,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    output logic          cpu_stall,
    output logic [1:0]    owner
);

    state_e        r_state;
    logic [1:0]    r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    logic [1:0]    w_mask;
    logic          w_bias;
    logic          w_vld;
    logic          w_m1;
    logic          w_latch;

    assign w_mask  = (r_state == ST_RESP) ? r_owner : OWN_NONE;
    assign w_latch = w_vld && (r_state == ST_IDLE || r_state == ST_RESP);

    dbus_arb_pick u_pick (
        .i_req  ({m1_req, m0_req}),
        .i_mask (w_mask),
        .i_bias (w_bias),
        .o_vld  (w_vld),
        .o_m1   (w_m1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE:  r_state <= w_vld ? ST_ISSUE : ST_IDLE;
                ST_ISSUE: r_state <= ST_RESP;
                ST_RESP:  r_state <= w_vld ? ST_ISSUE : ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
            // Slave address/data hold their last values until the next grant
            if (w_latch) begin
                r_owner <= w_m1 ? OWN_M1 : OWN_M0;
                r_we    <= w_m1 ? m1_we : m0_we;
                r_addr  <= w_m1 ? m1_addr : m0_addr;
                r_wdata <= w_m1 ? m1_wdata : m0_wdata;
            end
        end
    end

`ifdef DBUS_ARB_RR_EN
    logic r_ptr;

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= 1'b0;
        else if (w_latch)
            r_ptr <= ~w_m1;
    end

    assign w_bias = r_ptr;
`else
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] r_starve;
    logic       w_m1_busy;

    assign w_m1_busy = (r_owner == OWN_M1) && (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst || m1_ack || !m1_req)
            r_starve <= 8'd0;
        else if (!w_m1_busy && r_starve != LIMIT)
            r_starve <= r_starve + 8'd1;
    end

    assign w_bias = (r_starve == LIMIT);
`endif

    assign m0_ack    = (r_state == ST_RESP) && (r_owner == OWN_M0);
    assign m1_ack    = (r_state == ST_RESP) && (r_owner == OWN_M1);
    assign m0_rdata  = m0_ack ? s_rdata : '0;
    assign m1_rdata  = m1_ack ? s_rdata : '0;
    assign s_en      = (r_state == ST_ISSUE);
    assign s_we      = s_en & r_we;
    assign s_addr    = r_addr;
    assign s_wdata   = r_wdata;
    assign cpu_stall = m0_req & ~m0_ack;
    assign owner     = r_owner;

endmodule
